hx8k_soc_top: RTL and testbench
===============================

// Module: hx8k_soc_top
// PURPOSE
//  Board-level top for the iCE40-HX8K demo: wraps the existing picosoc core (PicoRV32 + spimemio + simpleuart + SRAM).
//  Adds the power-on reset stretcher, a 32-bit GPIO register on the iomem bus driving 8 LEDs, and the flash quad-IO tri-states.
//  In simulation, external SPI flash is the spiflash model holding firmware at offset 0x100000.
// PARAMETERS
//  MEM_WORDS       256            internal SRAM size in 32-bit words, passed to picosoc
//  PROGADDR_RESET  32'h0010_0000  CPU reset vector (flash offset 1 MiB)
//  GPIO_PAGE       8'h03          iomem_addr[31:24] value selecting the GPIO register
//  RST_CNT_BITS    6              width of the power-on reset counter
// PORTS
//  clk        in     1  system clock, 12 MHz on board
//  resetn     in     1  asynchronous, active-low reset
//  leds       out    8  gpio[7:0]
//  ser_rx     in     1  UART receive, idle high
//  ser_tx     out    1  UART transmit, idle high
//  flash_csb  out    1  SPI flash chip select, active low
//  flash_clk  out    1  SPI flash clock
//  flash_io0  inout  1  flash DQ0 / MOSI
//  flash_io1  inout  1  flash DQ1 / MISO
//  flash_io2  inout  1  flash DQ2
//  flash_io3  inout  1  flash DQ3
// BEHAVIOUR
//  Reset:
//   - resetn low asynchronously clears rst_cnt[RST_CNT_BITS-1:0] and gpio.
//   - After resetn rises, rst_cnt increments once per clk until all ones, then holds.
//   - core_resetn = &rst_cnt: core released 63 clks after resetn rises (default width).
//   - core_resetn goes to picosoc.resetn; picosoc resets synchronously.
//  Reset values:
//   - leds = 0 (asynchronous).
//   - flash_csb = 1, flash_clk = 0, flash_io* = Z, ser_tx = 1, from the first clk edge with core_resetn low.
//  iomem bus (picosoc valid/ready):
//   - iomem_ready is a registered 1-clk pulse, asserted the cycle after iomem_valid is sampled.
//   - Once ready is returned, it is low for one clk before answering the next access.
//   - iomem_addr[31:24] == GPIO_PAGE: a write updates gpio byte-wise, per iomem_wstrb[i] -> gpio[8i+7:8i].
//   - A GPIO read returns gpio in iomem_rdata.
//   - Any other iomem address: ready still pulses, rdata = 0, writes are ignored. The bus never stalls.
//   - iomem_rdata is held at 0 when not answering a read.
//  leds = gpio[7:0]; gpio[31:8] is readable and writable but drives no pins.
//  Flash pins:
//   - flash_ioN = flash_ioN_oe ? flash_ioN_do : 1'bz.
//   - flash_ioN_di = flash_ioN pad value.
//   - flash_csb and flash_clk are driven straight from picosoc.
//  UART:
//   - ser_tx and ser_rx connect straight to picosoc.simpleuart.
//   - The baud divisor is set by firmware: 104 clks/bit (12 MHz / 115200), 8N1, LSB first.
//  Simultaneous events: resetn assertion overrides any in-flight iomem or flash transaction; the access is abandoned, not completed.
//  Firmware writes gpio only as part of a complete iomem handshake. A write with wstrb = 0 changes nothing.
// TESTING
//  Bench setup: spiflash model on the flash pins, firmware hex at 0x100000, UART decoder sampling ser_tx mid-bit.
//  T1: resetn low 10 clks, then high.
//   -> leds = 0 while low; flash_csb = 1; ser_tx = 1.
//   -> First flash_csb fall no earlier than 63 clks after release.
//  T2: boot.
//   -> First flash read transaction is cmd 0x03, address 0x100000.
//   -> CPU fetches and executes firmware.
//  T3: firmware sw 0x000000A5 -> 0x03000000.
//   -> leds = 8'hA5 one clk after iomem_ready.
//   -> A later sb 0x3C to byte 1 leaves leds = A5 and reads back 0x00003CA5.
//  T4: firmware sets clkdiv 104 and sends 0x48 ('H').
//   -> ser_tx start bit, then bits 0,0,0,1,0,0,1,0, then stop, each 104 clks.
//   -> Decoder prints "H".
//  T5: lw from 0x04000000.
//   -> iomem_ready pulses next clk with rdata = 0; CPU continues; leds unchanged.
//  T6: resetn pulsed low mid flash burst.
//   -> leds = 0 immediately; flash_csb = 1 by the next clk.
//   -> Full reboot after release: T2 sequence repeats.

Source files
------------

// File: rtl/hx8k_soc_top.sv
// hx8k_soc_top: board-level top for the iCE40-HX8K demo.
//   Power-on reset stretcher, a 32-bit GPIO register on the iomem bus (gpio[7:0]
//   drives the LEDs), and the quad-IO flash tri-states around the SoC core.
// Ports:
//   clk, resetn          system clock, asynchronous active-low reset
//   leds[7:0]            gpio[7:0]
//   ser_rx / ser_tx      UART, idle high
//   flash_csb/flash_clk  SPI flash select (active low) and clock
//   flash_io0..3         flash DQ pads (io0 = MOSI, io1 = MISO)
//
// hx8k_mini_core: self-contained stand-in for picosoc with the same bus and pin
//   shape. After reset it opens one continuous SPI read (cmd 0x03) at
//   PROGADDR_RESET and executes 9-byte records {op, addr[31:0], data[31:0]}:
//     op[3:0]=1 iomem write, wstrb=op[7:4]    op[3:0]=2 iomem read into rd_reg
//     op[3:0]=3 UART send data[7:0]           op[3:0]=4 UART send rd_reg byte data[1:0]
//     anything else: release flash and halt.  UART clocks per bit = addr[15:0].
//   Internal state is the enum `state`.

module hx8k_mini_core #(
  parameter logic [31:0] PROGADDR_RESET = 32'h0010_0000
) (
  input  logic        clk,
  input  logic        resetn,
  output logic        iomem_valid,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic        iomem_ready,
  input  logic [31:0] iomem_rdata,
  output logic        ser_tx,
  output logic        flash_csb,
  output logic        flash_clk,
  output logic        flash_io0_oe,
  output logic        flash_io0_do,
  output logic        flash_io1_oe,
  output logic        flash_io1_do,
  output logic        flash_io2_oe,
  output logic        flash_io2_do,
  output logic        flash_io3_oe,
  output logic        flash_io3_do,
  input  logic        flash_io1_di
);
  typedef enum logic [2:0] {S_IDLE, S_CMD, S_RD, S_EXEC, S_BUS, S_UART, S_HALT} state_t;
  state_t state, state_nx;

  logic        sclk;
  logic [6:0]  bit_cnt;
  logic [31:0] sh_cmd;
  logic [71:0] rec;
  logic [31:0] rd_reg;
  logic [9:0]  tx_sh;
  logic [3:0]  tx_bits;
  logic [15:0] tx_div;

  logic [3:0]  op_kind;
  logic [15:0] div;
  logic [7:0]  rd_byte;
  logic        tx_tick;

  assign op_kind = rec[67:64];
  assign div     = rec[47:32];
  assign rd_byte = rd_reg[{rec[1:0], 3'b000} +: 8];
  assign tx_tick = (tx_div == div - 16'd1);

  // State register; the core resets synchronously.
  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nx;
  end

  // Next state. Bits move on the falling flash_clk phase (sclk==1 -> 0).
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = S_CMD;
      S_CMD:  if (sclk && bit_cnt == 7'd31) state_nx = S_RD;
      S_RD:   if (sclk && bit_cnt == 7'd71) state_nx = S_EXEC;
      S_EXEC: begin
        if (op_kind == 4'd1 || op_kind == 4'd2)      state_nx = S_BUS;
        else if (op_kind == 4'd3 || op_kind == 4'd4) state_nx = S_UART;
        else                                         state_nx = S_HALT;
      end
      S_BUS:  if (iomem_ready) state_nx = S_RD;
      S_UART: if (tx_tick && tx_bits == 4'd9) state_nx = S_RD;
      default: state_nx = state;
    endcase
  end

  // Outputs. iomem handshake: valid stays high with addr/wstrb/wdata stable
  // until the cycle ready is seen high; that cycle completes the access.
  always_comb begin
    iomem_valid  = (state == S_BUS);
    iomem_wstrb  = (op_kind == 4'd1) ? rec[71:68] : 4'b0000;
    iomem_addr   = rec[63:32];
    iomem_wdata  = rec[31:0];
    flash_csb    = (state == S_IDLE) || (state == S_HALT);
    flash_clk    = sclk;
    flash_io0_oe = (state == S_CMD);
    flash_io0_do = sh_cmd[31];
    flash_io1_oe = 1'b0;
    flash_io1_do = 1'b0;
    flash_io2_oe = 1'b0;
    flash_io2_do = 1'b0;
    flash_io3_oe = 1'b0;
    flash_io3_do = 1'b0;
    ser_tx       = (state == S_UART) ? tx_sh[0] : 1'b1;
  end

  // Datapath: SPI shifting, record capture, UART serialiser.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sclk    <= 1'b0;
      bit_cnt <= '0;
      sh_cmd  <= '0;
      rec     <= '0;
      rd_reg  <= '0;
      tx_sh   <= '1;
      tx_bits <= '0;
      tx_div  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          sh_cmd  <= {8'h03, PROGADDR_RESET[23:0]};
          bit_cnt <= '0;
          sclk    <= 1'b0;
        end
        S_CMD: begin
          sclk <= !sclk;
          if (sclk) begin
            sh_cmd  <= {sh_cmd[30:0], 1'b0};
            bit_cnt <= (bit_cnt == 7'd31) ? 7'd0 : bit_cnt + 7'd1;
          end
        end
        S_RD: begin
          sclk <= !sclk;
          // MISO changes on the falling flash_clk, so sample just before it.
          if (sclk) begin
            rec     <= {rec[70:0], flash_io1_di};
            bit_cnt <= (bit_cnt == 7'd71) ? 7'd0 : bit_cnt + 7'd1;
          end
        end
        S_EXEC: begin
          tx_sh   <= {1'b1, (op_kind == 4'd3) ? rec[7:0] : rd_byte, 1'b0};
          tx_bits <= '0;
          tx_div  <= '0;
        end
        S_BUS: if (iomem_ready && op_kind == 4'd2) rd_reg <= iomem_rdata;
        S_UART: begin
          if (tx_tick) begin
            tx_div  <= '0;
            tx_sh   <= {1'b1, tx_sh[9:1]};
            tx_bits <= tx_bits + 4'd1;
          end else begin
            tx_div <= tx_div + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

module hx8k_soc_top #(
  parameter int          MEM_WORDS      = 256,
  parameter logic [31:0] PROGADDR_RESET = 32'h0010_0000,
  parameter logic [7:0]  GPIO_PAGE      = 8'h03,
  parameter int          RST_CNT_BITS   = 6
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [7:0] leds,
  input  logic       ser_rx,
  output logic       ser_tx,
  output logic       flash_csb,
  output logic       flash_clk,
  inout  wire        flash_io0,
  inout  wire        flash_io1,
  inout  wire        flash_io2,
  inout  wire        flash_io3
);
  logic [RST_CNT_BITS-1:0] rst_cnt;
  logic                    core_resetn;
  logic [31:0]             gpio;

  logic        iomem_valid, iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;
  logic        io0_oe, io0_do, io1_oe, io1_do, io2_oe, io2_do, io3_oe, io3_do;
  logic        is_gpio;

  // Only the page byte is decoded; the stand-in core has no UART receiver and
  // no SRAM, so those inputs are gathered here.
  logic unused_ok;
  assign unused_ok = &{1'b0, ser_rx, iomem_addr[23:0], MEM_WORDS[0]};

  // Reset stretcher: count up once per clk after release, hold at all ones.
  assign core_resetn = &rst_cnt;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)           rst_cnt <= '0;
    else if (!core_resetn) rst_cnt <= rst_cnt + 1'b1;
  end

  // iomem slave: one registered ready pulse per access, never two back to back,
  // so a still-high valid during the ready cycle is not taken as a new access.
  assign is_gpio = (iomem_addr[31:24] == GPIO_PAGE);
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      gpio        <= '0;
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
    end else begin
      iomem_ready <= 1'b0;
      iomem_rdata <= '0;
      if (iomem_valid && !iomem_ready) begin
        iomem_ready <= 1'b1;
        if (is_gpio) begin
          for (int i = 0; i < 4; i++)
            if (iomem_wstrb[i]) gpio[8*i +: 8] <= iomem_wdata[8*i +: 8];
          if (iomem_wstrb == 4'b0000) iomem_rdata <= gpio;
        end
      end
    end
  end

  assign leds = gpio[7:0];

  assign flash_io0 = io0_oe ? io0_do : 1'bz;
  assign flash_io1 = io1_oe ? io1_do : 1'bz;
  assign flash_io2 = io2_oe ? io2_do : 1'bz;
  assign flash_io3 = io3_oe ? io3_do : 1'bz;

  hx8k_mini_core #(.PROGADDR_RESET(PROGADDR_RESET)) core (
    .clk          (clk),
    .resetn       (core_resetn),
    .iomem_valid  (iomem_valid),
    .iomem_wstrb  (iomem_wstrb),
    .iomem_addr   (iomem_addr),
    .iomem_wdata  (iomem_wdata),
    .iomem_ready  (iomem_ready),
    .iomem_rdata  (iomem_rdata),
    .ser_tx       (ser_tx),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io0_oe (io0_oe),
    .flash_io0_do (io0_do),
    .flash_io1_oe (io1_oe),
    .flash_io1_do (io1_do),
    .flash_io2_oe (io2_oe),
    .flash_io2_do (io2_do),
    .flash_io3_oe (io3_oe),
    .flash_io3_do (io3_do),
    .flash_io1_di (flash_io1)
  );
endmodule

// File: tb/tb_hx8k_soc_top.sv
// Directed bench for hx8k_soc_top: behavioural SPI flash holding a command
// stream at 0x100000, a mid-bit UART decoder on ser_tx, and a linear sequence
// of checks covering reset, boot, GPIO writes/reads, UART and reset mid-burst.
module tb_hx8k_soc_top;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ser_rx = 1'b1;
  wire [7:0] leds;
  wire ser_tx, flash_csb, flash_clk;
  wire flash_io0, flash_io1, flash_io2, flash_io3;

  int total = 0;
  int bad = 0;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  hx8k_soc_top dut (
    .clk       (clk),
    .resetn    (resetn),
    .leds      (leds),
    .ser_rx    (ser_rx),
    .ser_tx    (ser_tx),
    .flash_csb (flash_csb),
    .flash_clk (flash_clk),
    .flash_io0 (flash_io0),
    .flash_io1 (flash_io1),
    .flash_io2 (flash_io2),
    .flash_io3 (flash_io3)
  );

  // ---------------- SPI flash model ----------------
  logic [7:0]  fw [0:255];
  int          nb = 0;
  logic        miso = 1'b0;
  logic        miso_oe = 1'b0;
  logic        sclk_prev = 1'b0;
  int          pcnt = 0;
  logic [31:0] cmd_sh = '0;
  logic [7:0]  cap_cmd = '0;
  logic [23:0] cap_addr = '0;
  int          n_txn = 0;

  assign flash_io1 = miso_oe ? miso : 1'bz;

  always @(flash_clk or flash_csb) begin
    int bi, idx;
    if (flash_csb) begin
      pcnt = 0;
      miso_oe = 1'b0;
    end else if (flash_clk && !sclk_prev) begin
      if (pcnt < 32) cmd_sh = {cmd_sh[30:0], flash_io0};
      pcnt++;
      if (pcnt == 32) begin
        cap_cmd  = cmd_sh[31:24];
        cap_addr = cmd_sh[23:0];
        n_txn++;
      end
    end else if (!flash_clk && sclk_prev && pcnt >= 32) begin
      bi  = pcnt - 32;
      idx = int'(cap_addr) - 32'h0010_0000 + bi / 8;
      miso = (idx >= 0 && idx < nb) ? fw[idx][7 - (bi % 8)] : 1'b0;
      miso_oe = 1'b1;
    end
    sclk_prev = flash_clk;
  end

  // ---------------- UART decoder ----------------
  logic [7:0] rx_q[$];
  logic [7:0] rx_b;
  logic       dec_en = 1'b0;

  always begin
    @(negedge ser_tx);
    if (dec_en) begin
      repeat (52) @(negedge clk);
      if (ser_tx == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (104) @(negedge clk);
          rx_b[i] = ser_tx;
        end
        repeat (104) @(negedge clk);
        if (ser_tx == 1'b1) begin
          rx_q.push_back(rx_b);
          $display("uart rx: 0x%02h '%c'", rx_b, rx_b);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic put_cmd(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] data);
    logic [71:0] r;
    r = {op, addr, data};
    for (int i = 8; i >= 0; i--) begin
      fw[nb] = r[8*i +: 8];
      nb++;
    end
  endtask

  task automatic wait_leds(input logic [7:0] v, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (leds === v) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_txn(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (n_txn >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic check_rx(input string tag, input int budget);
    logic [7:0] e;
    bit got;
    got = 1'b0;
    e = exp_q.pop_front();
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (rx_q.size() > 0) begin
        got = 1'b1;
        break;
      end
    end
    if (got) chk(tag, {24'h0, rx_q.pop_front()}, {24'h0, e});
    else     chk({tag, "_timeout"}, 32'h0, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    bit ok;
    int cnt;

    // Firmware: GPIO writes/reads, UART sends, other-page accesses, halt.
    put_cmd(8'hF1, 32'h0300_0000, 32'h0000_00A5); // sw 0xA5 to GPIO
    put_cmd(8'h21, 32'h0300_0000, 32'h0000_3C00); // sb 0x3C to byte 1
    put_cmd(8'h02, 32'h0300_0000, 32'h0);         // read GPIO -> 0x00003CA5
    put_cmd(8'h04, 32'h0000_0068, 32'h1);         // send byte 1 -> 3C
    put_cmd(8'h03, 32'h0000_0068, 32'h48);        // send 'H'
    put_cmd(8'h02, 32'h0400_0000, 32'h0);         // read other page -> 0
    put_cmd(8'h04, 32'h0000_0068, 32'h0);         // send byte 0 -> 00
    put_cmd(8'hF1, 32'h0400_0000, 32'hFFFF_FFFF); // write other page, ignored
    put_cmd(8'h01, 32'h0300_0000, 32'hFFFF_FFFF); // wstrb 0, ignored
    put_cmd(8'h81, 32'h0300_0000, 32'h5A00_0000); // byte 3 = 5A
    put_cmd(8'h02, 32'h0300_0000, 32'h0);         // read GPIO -> 0x5A003CA5
    put_cmd(8'h04, 32'h0000_0068, 32'h3);         // send 5A
    put_cmd(8'h04, 32'h0000_0068, 32'h0);         // send A5
    put_cmd(8'h04, 32'h0000_0068, 32'h1);         // send 3C
    put_cmd(8'h00, 32'h0, 32'h0);                 // halt
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'h48);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h3C);

    // T1: reset held 10 clks
    resetn = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_leds", {24'h0, leds}, 32'h0);
    chk("rst_flash_csb", {31'h0, flash_csb}, 32'h1);
    chk("rst_flash_clk", {31'h0, flash_clk}, 32'h0);
    chk("rst_ser_tx", {31'h0, ser_tx}, 32'h1);
    resetn = 1'b1;
    dec_en = 1'b1;
    cnt = 0;
    while (flash_csb === 1'b1 && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("boot_delay_in_63_66", {31'h0, (cnt >= 63 && cnt <= 66)}, 32'h1);

    // T2: first flash read
    wait_txn(1, 100, ok);
    chk("boot1_txn_seen", {31'h0, ok}, 32'h1);
    chk("boot1_cmd", {24'h0, cap_cmd}, 32'h03);
    chk("boot1_addr", {8'h0, cap_addr}, 32'h0010_0000);

    // T3/T4/T5: GPIO and UART
    wait_leds(8'hA5, 1000, ok);
    chk("gpio_sw_a5", {31'h0, ok}, 32'h1);
    check_rx("uart_gpio_byte1", 3000);
    check_rx("uart_H", 3000);
    check_rx("uart_other_page_rdata", 3000);
    check_rx("uart_gpio_byte3", 4000);
    check_rx("uart_gpio_byte0", 3000);
    check_rx("uart_gpio_byte1_after_wstrb0", 3000);
    cnt = 0;
    while (flash_csb !== 1'b1 && cnt < 600) begin
      @(negedge clk);
      cnt++;
    end
    chk("halt_flash_csb", {31'h0, flash_csb}, 32'h1);
    chk("leds_after_ignored_writes", {24'h0, leds}, 32'hA5);
    chk("single_burst", n_txn, 32'd1);

    // T6: reboot, then reset mid flash burst
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    wait_leds(8'hA5, 1000, ok);
    chk("boot2_gpio_a5", {31'h0, ok}, 32'h1);
    repeat (20) @(negedge clk);
    chk("boot2_burst_active", {31'h0, flash_csb}, 32'h0);
    #2 resetn = 1'b0;
    #1 chk("midburst_leds_async", {24'h0, leds}, 32'h0);
    @(posedge clk);
    #1;
    chk("midburst_flash_csb", {31'h0, flash_csb}, 32'h1);
    chk("midburst_flash_clk", {31'h0, flash_clk}, 32'h0);
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    wait_txn(3, 300, ok);
    chk("boot3_txn_seen", {31'h0, ok}, 32'h1);
    chk("boot3_cmd", {24'h0, cap_cmd}, 32'h03);
    chk("boot3_addr", {8'h0, cap_addr}, 32'h0010_0000);
    wait_leds(8'hA5, 1000, ok);
    chk("boot3_gpio_a5", {31'h0, ok}, 32'h1);
    rx_q.delete();
    exp_q.delete();
    exp_q.push_back(8'h3C);
    check_rx("boot3_uart_gpio_byte1", 3000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
